// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : PC holder and 8-bit instruction producer (FETCH/WAIT/ISSUE) with
//            valid/ready issue, redirects and jal link output. The optional
//            halt-on-PC-wrap behaviour is enabled by IFU_HALT_ON_WRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd_en,
  input  logic [7:0]        imem_rdata,
  output logic [7:0]        instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              link_valid,
  output logic [ADDR_W-1:0] link_addr,
`ifdef IFU_HALT_ON_WRAP_EN
  output logic              halted,
`endif
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] C_RESET_PC = ADDR_W'(RESET_PC);
  localparam logic [3:0]        C_OP_JAL   = 4'b1111;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_instr;
  logic              r_instr_valid;
  logic              r_link_valid;
  logic [ADDR_W-1:0] r_link_addr;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_handshake;
`ifdef IFU_HALT_ON_WRAP_EN
  logic              r_halted;
`endif

  assign w_pc_inc    = r_pc + ADDR_W'(1);
  assign w_handshake = r_instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_pc          <= C_RESET_PC;
      r_instr       <= 8'h00;
      r_instr_valid <= 1'b0;
      r_link_valid  <= 1'b0;
      r_link_addr   <= '0;
`ifdef IFU_HALT_ON_WRAP_EN
      r_halted      <= 1'b0;
`endif
    end else begin
      // The link pulse is independent of any redirect arriving alongside it.
      r_link_valid <= 1'b0;
      if (w_handshake && (r_instr[7:4] == C_OP_JAL)) begin
        r_link_valid <= 1'b1;
        r_link_addr  <= w_pc_inc;
      end

      if (redirect_valid) begin
        r_pc          <= redirect_target;
        r_state       <= S_FETCH;
        r_instr_valid <= 1'b0;
`ifdef IFU_HALT_ON_WRAP_EN
        r_halted      <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_FETCH: r_state <= S_WAIT;
          S_WAIT: begin
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_state       <= S_ISSUE;
          end
          S_ISSUE: begin
            if (instr_ready) begin
              r_instr_valid <= 1'b0;
`ifdef IFU_HALT_ON_WRAP_EN
              if (&r_pc) begin
                r_state  <= S_HALT;
                r_halted <= 1'b1;
              end else begin
                r_pc    <= w_pc_inc;
                r_state <= S_FETCH;
              end
`else
              r_pc    <= w_pc_inc;
              r_state <= S_FETCH;
`endif
            end
          end
          S_HALT:  r_state <= S_HALT;
          default: r_state <= S_FETCH;
        endcase
      end
    end
  end

  // The strobe follows the state register; reset masks the FETCH that reset itself loads.
  assign imem_rd_en  = (r_state == S_FETCH) && !reset;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign link_valid  = r_link_valid;
  assign link_addr   = r_link_addr;
`ifdef IFU_HALT_ON_WRAP_EN
  assign halted      = r_halted;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Self-checking bench for instr_fetch_unit with a 1-cycle memory
//            model and an issue scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic       clk;
  logic       reset;
  logic [7:0] imem_addr;
  logic       imem_rd_en;
  logic [7:0] imem_rdata;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       redirect_valid;
  logic [7:0] redirect_target;
  logic       link_valid;
  logic [7:0] link_addr;
  logic [7:0] pc;
`ifdef IFU_HALT_ON_WRAP_EN
  logic       halted;
`endif

  instr_fetch_unit #(.ADDR_W(8), .RESET_PC(0)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_rd_en      (imem_rd_en),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .link_valid      (link_valid),
    .link_addr       (link_addr),
`ifdef IFU_HALT_ON_WRAP_EN
    .halted          (halted),
`endif
    .pc              (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [256];

  // Synchronous 1-cycle read; idle cycles return a poison byte.
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
    else            imem_rdata <= 8'hEE;
  end

  typedef struct {
    logic [7:0] instr;
    logic [7:0] pc;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every handshake must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_issue: got instr 0x%0h pc 0x%0h, expected none", instr, pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sb_instr", {24'd0, instr}, {24'd0, e.instr});
        check("sb_pc", {24'd0, pc}, {24'd0, e.pc});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic redirect_to(input logic [7:0] t);
    redirect_valid  = 1'b1;
    redirect_target = t;
    tick();
    redirect_valid  = 1'b0;
  endtask

  task automatic push(input logic [7:0] i, input logic [7:0] p);
    exp_t e;
    e.instr = i;
    e.pc    = p;
    q.push_back(e);
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 20; k++) begin
      if (instr_valid) return;
      tick();
    end
    n_checks++;
    n_errors++;
    $display("FAIL %s: got no instr_valid within 20 cycles, expected instr_valid=1", name);
  endtask

  typedef struct {
    logic [7:0] target;
    logic [7:0] data;
    int         stall;
    logic       exp_link;
    logic [7:0] exp_link_addr;
    logic [7:0] exp_next_pc;
  } vec_t;
  vec_t vecs [5];

  initial begin
    vecs[0] = '{8'h30, 8'h12, 0, 1'b0, 8'h11, 8'h31};
    vecs[1] = '{8'h31, 8'hF0, 2, 1'b1, 8'h32, 8'h32};
    vecs[2] = '{8'h7F, 8'hFF, 1, 1'b1, 8'h80, 8'h80};
    vecs[3] = '{8'hA5, 8'hE7, 3, 1'b0, 8'h80, 8'hA6};
    vecs[4] = '{8'hFE, 8'hF1, 0, 1'b1, 8'hFF, 8'hFF};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h04; mem[8'h01] = 8'h19; mem[8'h02] = 8'h2E;
    mem[8'h10] = 8'hF3; mem[8'h20] = 8'hAA; mem[8'h40] = 8'h5C;
    mem[8'h60] = 8'h3C; mem[8'hFF] = 8'h7A;
    for (int i = 0; i < 5; i++) mem[vecs[i].target] = vecs[i].data;

    imem_rdata = 8'h00;
    reset = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b0; redirect_target = 8'h00;
    repeat (3) tick();

    check("rst_pc", {24'd0, pc}, 32'h0);
    check("rst_instr", {24'd0, instr}, 32'h0);
    check("rst_valid", {31'd0, instr_valid}, 32'h0);
    check("rst_rd_en", {31'd0, imem_rd_en}, 32'h0);
    check("rst_link_valid", {31'd0, link_valid}, 32'h0);
    check("rst_link_addr", {24'd0, link_addr}, 32'h0);

    // Free run: valid on cycles 3/6/9, one read strobe at the start of each triple.
    push(8'h04, 8'h00); push(8'h19, 8'h01); push(8'h2E, 8'h02);
    reset = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 1) #1;
      else tick();
      check($sformatf("run_valid_c%0d", c), {31'd0, instr_valid}, {31'd0, (c % 3) == 0});
      check($sformatf("run_rd_en_c%0d", c), {31'd0, imem_rd_en}, {31'd0, (c % 3) == 1});
      if ((c % 3) == 1) check($sformatf("run_addr_c%0d", c), {24'd0, imem_addr}, (c - 1) / 3);
    end
    tick();
    instr_ready = 1'b0;

    // Backpressure on 8'h19 at pc 1.
    redirect_to(8'h01);
    push(8'h19, 8'h01);
    wait_valid("bp_wait");
    for (int k = 0; k < 5; k++) begin
      check("bp_instr", {24'd0, instr}, 32'h19);
      check("bp_valid", {31'd0, instr_valid}, 32'h1);
      check("bp_rd_en", {31'd0, imem_rd_en}, 32'h0);
      check("bp_pc", {24'd0, pc}, 32'h01);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("bp_pc_after", {24'd0, pc}, 32'h02);
    check("bp_valid_after", {31'd0, instr_valid}, 32'h0);

    // Redirect while the read of 8'h20 is in flight.
    redirect_to(8'h20);
    check("rw_fetch_rd", {31'd0, imem_rd_en}, 32'h1);
    check("rw_fetch_addr", {24'd0, imem_addr}, 32'h20);
    tick();
    check("rw_wait_rd", {31'd0, imem_rd_en}, 32'h0);
    redirect_to(8'h40);
    check("rw_new_rd", {31'd0, imem_rd_en}, 32'h1);
    check("rw_new_addr", {24'd0, imem_addr}, 32'h40);
    push(8'h5C, 8'h40);
    instr_ready = 1'b1;
    wait_valid("rw_wait");
    tick();
    instr_ready = 1'b0;

    // Back-to-back redirects: newest target wins.
    redirect_valid = 1'b1; redirect_target = 8'h50;
    tick();
    redirect_target = 8'h60;
    tick();
    redirect_valid = 1'b0;
    check("b2b_addr", {24'd0, imem_addr}, 32'h60);
    check("b2b_rd", {31'd0, imem_rd_en}, 32'h1);
    push(8'h3C, 8'h60);
    instr_ready = 1'b1;
    wait_valid("b2b_wait");
    tick();
    instr_ready = 1'b0;

    // jal at 8'h10 consumed together with a redirect to 8'h03.
    redirect_to(8'h10);
    push(8'hF3, 8'h10);
    wait_valid("jal_wait");
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 8'h03;
    tick();
    instr_ready = 1'b0; redirect_valid = 1'b0;
    check("jal_link_valid", {31'd0, link_valid}, 32'h1);
    check("jal_link_addr", {24'd0, link_addr}, 32'h11);
    check("jal_fetch_addr", {24'd0, imem_addr}, 32'h03);
    check("jal_fetch_rd", {31'd0, imem_rd_en}, 32'h1);
    tick();
    check("jal_link_pulse_end", {31'd0, link_valid}, 32'h0);
    check("jal_link_hold", {24'd0, link_addr}, 32'h11);

    // Handshake at pc 8'hFF.
    redirect_to(8'hFF);
    push(8'h7A, 8'hFF);
    wait_valid("wrap_wait");
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
`ifdef IFU_HALT_ON_WRAP_EN
    check("halt_flag", {31'd0, halted}, 32'h1);
    check("halt_pc", {24'd0, pc}, 32'hFF);
    for (int k = 0; k < 3; k++) begin
      check("halt_rd_en", {31'd0, imem_rd_en}, 32'h0);
      check("halt_valid", {31'd0, instr_valid}, 32'h0);
      tick();
    end
    redirect_to(8'h00);
    check("halt_cleared", {31'd0, halted}, 32'h0);
    check("halt_resume_rd", {31'd0, imem_rd_en}, 32'h1);
    check("halt_resume_addr", {24'd0, imem_addr}, 32'h00);
`else
    check("wrap_rd", {31'd0, imem_rd_en}, 32'h1);
    check("wrap_addr", {24'd0, imem_addr}, 32'h00);
    check("wrap_pc", {24'd0, pc}, 32'h00);
`endif

    // Table-driven single issues with varying stall lengths.
    for (int i = 0; i < 5; i++) begin
      redirect_to(vecs[i].target);
      push(vecs[i].data, vecs[i].target);
      wait_valid($sformatf("vec%0d_wait", i));
      repeat (vecs[i].stall) tick();
      check($sformatf("vec%0d_held", i), {24'd0, instr}, {24'd0, vecs[i].data});
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      check($sformatf("vec%0d_link_valid", i), {31'd0, link_valid}, {31'd0, vecs[i].exp_link});
      check($sformatf("vec%0d_link_addr", i), {24'd0, link_addr}, {24'd0, vecs[i].exp_link_addr});
      check($sformatf("vec%0d_pc", i), {24'd0, pc}, {24'd0, vecs[i].exp_next_pc});
      check($sformatf("vec%0d_valid", i), {31'd0, instr_valid}, 32'h0);
    end

    // Reset while a jal sits in ISSUE: it is discarded, never consumed.
    redirect_to(8'h10);
    wait_valid("rst_issue_wait");
    reset = 1'b1;
    tick();
    check("rst_issue_valid", {31'd0, instr_valid}, 32'h0);
    check("rst_issue_pc", {24'd0, pc}, 32'h0);
    check("rst_issue_link", {31'd0, link_valid}, 32'h0);
    check("rst_issue_link_addr", {24'd0, link_addr}, 32'h0);
    reset = 1'b0;
    #1;
    check("rst_issue_refetch", {31'd0, imem_rd_en}, 32'h1);
    check("sb_drained", q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer side of the 8-bit instruction stream consumed by the control unit.
- Holds the program counter and reads instruction memory, which has a synchronous 1-cycle read.
- Presents each instruction with a valid/ready handshake and accepts PC redirects for taken branches and jumps.
- Emits the return address when a jal (opcode 4'b1111) is issued.

Parameters:
ADDR_W, 8, width of PC and instruction-memory address
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
imem_addr  output  ADDR_W  instruction memory read address
imem_rd_en  output  1  instruction memory read strobe
imem_rdata  input  8  read data, valid the cycle after imem_rd_en
instr  output  8  instruction to decoder; opcode [7:4], operands [3:2],[1:0]
instr_valid  output  1  instr is valid
instr_ready  input  1  decoder accepts instr
redirect_valid  input  1  load PC from redirect_target (taken branch/jump)
redirect_target  input  ADDR_W  new PC
link_valid  output  1  one-cycle pulse: jal issued
link_addr  output  ADDR_W  return address (jal PC + 1)
pc  output  ADDR_W  current PC

Behaviour:
- Reset (reset=1 at clock edge; clock is clk, reset is reset, synchronous, active-high):
  - pc=RESET_PC, state=FETCH.
  - instr=8'h00, instr_valid=0, imem_rd_en=0, link_valid=0, link_addr=0.
  - Reset mid-fetch or mid-issue discards the instruction in flight.
- FSM states FETCH, WAIT, ISSUE:
  - FETCH: imem_rd_en=1 and imem_addr=pc, both registered so they appear this cycle. Next state WAIT.
  - WAIT: imem_rd_en=0; capture imem_rdata into the instr register. Next state ISSUE.
  - ISSUE: instr_valid=1; instr held stable while instr_ready=0.
  - ISSUE on handshake (instr_valid & instr_ready): pc <= pc+1 (mod 2^ADDR_W), next state FETCH, instr_valid=0 the following cycle.
- Throughput and latency:
  - Minimum 3 cycles per instruction.
  - First instr_valid appears 3 cycles after reset is released: FETCH, WAIT, then ISSUE.
- Redirect (highest priority below reset), sampled in every state:
  - pc <= redirect_target, next state FETCH, instr_valid=0 next cycle.
  - Any read in flight (in WAIT) is discarded.
  - Redirect together with a handshake in ISSUE: the instruction counts as consumed, and pc takes redirect_target, not pc+1.
  - Redirect in back-to-back cycles: the last one wins; FETCH repeats with the newest target.
- Link:
  - On a handshake where instr[7:4]==4'b1111, link_valid=1 for exactly the next cycle, with link_addr = issuing pc + 1 (wrapped).
  - link_addr holds its value until the next jal.
  - A redirect arriving in the same cycle does not suppress the link pulse.
- PC wrap: pc at all-ones increments to 0 (default build).
- imem_rd_en is never asserted in WAIT or ISSUE. At most one read is outstanding.

Optional Feature:
- Macro IFU_HALT_ON_WRAP_EN.
- Defined:
  - Adds output halted (1 bit, reset 0) and a HALT state.
  - A handshake in ISSUE with pc == all-ones goes to HALT instead of wrapping; halted=1 and pc is held.
  - In HALT: no reads, instr_valid=0.
  - Only reset or redirect_valid leaves HALT; redirect clears halted and goes to FETCH.
- Undefined: no halted port, no HALT state; PC wraps to 0.

Test Plan:
- Reset then free-run with instr_ready=1 and imem[0..2]=8'h04,8'h19,8'h2E:
  - instr_valid at cycles 3, 6, 9 after reset release, carrying 8'h04, 8'h19, 8'h2E.
  - imem_addr 0, 1, 2 with one rd_en pulse each.
- Backpressure: hold instr_ready=0 for 5 cycles in ISSUE with instr=8'h19:
  - instr stable, no imem_rd_en, pc stays 1.
  - After ready: pc=2.
- Redirect in WAIT with redirect_target=8'h40:
  - The fetched data is discarded and never presented.
  - Next imem_addr=8'h40; the next instr is imem[8'h40].
- jal 8'hF3 at pc=8'h10, handshake with simultaneous redirect to 8'h03:
  - link_valid pulses 1 cycle with link_addr=8'h11.
  - Next fetch address is 8'h03.
- pc=8'hFF handshake:
  - Default build: next imem_addr=8'h00.
  - With IFU_HALT_ON_WRAP_EN: halted=1, no further rd_en; redirect to 8'h00 resumes fetch at 0 and clears halted.
- Assert reset in ISSUE with instr_valid=1:
  - Next cycle instr_valid=0, pc=RESET_PC, link_valid=0.
